// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin merge of two byte sources into a shared TX FIFO,
// drained one frame at a time into a UART transmitter with gap and done-timeout.
module uart_tx_sched #(
  parameter int B    = 8,
  parameter int GAP  = 2,
  parameter int TO_W = 16
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         enable_i,
  input  logic         s0_valid_i,
  input  logic [B-1:0] s0_data_i,
  output logic         s0_ready_o,
  input  logic         s1_valid_i,
  input  logic [B-1:0] s1_data_i,
  output logic         s1_ready_o,
  output logic         fifo_wr_o,
  output logic [B-1:0] fifo_wr_data_o,
  input  logic         fifo_full_i,
  output logic         fifo_rd_o,
  input  logic [B-1:0] fifo_rd_data_i,
  input  logic         fifo_empty_i,
  output logic         tx_start_o,
  output logic [B-1:0] tx_data_o,
  input  logic         tx_done_i,
  output logic         busy_o,
  output logic         timeout_err_o
);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, GAPS} state_t;
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  state_t          state_q, state_d;
  logic            rr_q, rr_d, grant, wr_allowed, to_hit;
  logic [GW-1:0]   gap_q, gap_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [B-1:0]    tx_data_q, tx_data_d;
  // Writes are held off during LOAD so the FIFO never sees a push and a pop together.
  assign wr_allowed     = ~fifo_full_i & (state_q != LOAD);
  assign grant          = (s0_valid_i & s1_valid_i) ? rr_q : s1_valid_i;
  assign s0_ready_o     = wr_allowed & s0_valid_i & ~grant;
  assign s1_ready_o     = wr_allowed & s1_valid_i & grant;
  assign fifo_wr_o      = s0_ready_o | s1_ready_o;
  assign fifo_wr_data_o = fifo_wr_o ? (grant ? s1_data_i : s0_data_i) : '0;
  assign rr_d           = fifo_wr_o ? ~grant : rr_q;
  // The last WAIT cycle of the timeout window is the one where the counter sits at 2**TO_W-2.
  assign to_hit         = (state_q == WAIT) & ~tx_done_i & (to_q == {{(TO_W-1){1'b1}}, 1'b0});
  assign fifo_rd_o      = state_q == LOAD;
  assign tx_start_o     = state_q == START;
  assign busy_o         = state_q != IDLE;
  assign timeout_err_o  = to_hit;
  assign tx_data_o      = tx_data_q;
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    to_d      = to_q;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE:  state_d = (enable_i & ~fifo_empty_i) ? LOAD : IDLE;
      LOAD: begin
        tx_data_d = fifo_rd_data_i;
        state_d   = START;
      end
      START: begin
        to_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        to_d    = to_q + 1'b1;
        gap_d   = '0;
        state_d = tx_done_i ? ((GAP == 0) ? IDLE : GAPS) : (to_hit ? IDLE : WAIT);
      end
      GAPS: begin
        gap_d   = gap_q + 1'b1;
        state_d = (int'(gap_q) == GAP - 1) ? IDLE : GAPS;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      gap_q     <= '0;
      to_q      <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gap_q     <= gap_d;
      to_q      <= to_d;
      tx_data_q <= tx_data_d;
    end
  end
endmodule
